punc_control_fsm: RTL

//  Multicycle LC3 control unit; drives every control input of the PUnC datapath.

---
 rtl/punc_control_fsm_if.sv | 42 ++++
 rtl/punc_control_fsm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control_fsm_if.sv
// Control bundle between the PUnC control FSM (master) and the datapath (slave):
// instruction word and condition codes in, every datapath enable and mux select out.
interface punc_control_fsm_if;
    logic [15:0] ir;
    logic        N;
    logic        Z;
    logic        P;
    logic        ir_w_en;
    logic        pc_ld;
    logic        mem_w_en;
    logic        rf_w_en;
    logic        indirect_en;
    logic        status_ld;
    logic [1:0]  pc_src_sel;
    logic [2:0]  mem_r_addr_sel;
    logic        mem_w_addr_sel;
    logic        rf_r_addr_0_sel;
    logic        rf_r_addr_1_sel;
    logic        rf_w_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        status_src_sel;
    logic [1:0]  alu_op;
    logic [1:0]  alu_A_sel;
    logic [2:0]  alu_B_sel;
    logic        halted;

    modport master (
        input  ir, N, Z, P,
        output ir_w_en, pc_ld, mem_w_en, rf_w_en, indirect_en, status_ld,
               pc_src_sel, mem_r_addr_sel, mem_w_addr_sel, rf_r_addr_0_sel,
               rf_r_addr_1_sel, rf_w_addr_sel, rf_w_data_sel, status_src_sel,
               alu_op, alu_A_sel, alu_B_sel, halted
    );

    modport slave (
        output ir, N, Z, P,
        input  ir_w_en, pc_ld, mem_w_en, rf_w_en, indirect_en, status_ld,
               pc_src_sel, mem_r_addr_sel, mem_w_addr_sel, rf_r_addr_0_sel,
               rf_r_addr_1_sel, rf_w_addr_sel, rf_w_data_sel, status_src_sel,
               alu_op, alu_A_sel, alu_B_sel, halted
    );
endinterface

// File: rtl/punc_control_fsm.sv
// Multicycle LC3 control unit: FETCH/DECODE/EXECUTE(/EXECUTE2) sequencing for the PUnC datapath.
// Optional PUNC_LEA_SETCC_EN: LEA also updates N/Z/P from the ALU result.
module punc_control_fsm #(
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    punc_control_fsm_if.master bus
);
    localparam logic [1:0] PC_SRC_SEL_INC = 2'd0, PC_SRC_SEL_ALU = 2'd1, PC_SRC_SEL_REG = 2'd2;
    localparam logic [2:0] MEM_R_PC = 3'd0, MEM_R_ALU = 3'd1, MEM_R_IND = 3'd2;
    localparam logic       MEM_W_ALU = 1'b0, MEM_W_IND = 1'b1;
    localparam logic       RF_R0_IR_8_6 = 1'b0, RF_R0_IR_11_9 = 1'b1;
    localparam logic       RF_R1_IR_2_0 = 1'b0, RF_R1_IR_8_6 = 1'b1;
    localparam logic       RF_W_ADDR_IR_11_9 = 1'b0, RF_W_ADDR_R7 = 1'b1;
    localparam logic [1:0] RF_W_DATA_ALU = 2'd0, RF_W_DATA_MEM = 2'd1, RF_W_DATA_PC = 2'd2;
    localparam logic       STATUS_SRC_SEL_ALU = 1'b0, STATUS_SRC_SEL_MEM = 1'b1;
    localparam logic [1:0] ALU_FN_ADD = 2'd0, ALU_FN_AND = 2'd1, ALU_FN_NOT = 2'd2;
    localparam logic [1:0] ALU_SRC_A_REG_0 = 2'd0, ALU_SRC_A_PC = 2'd1, ALU_SRC_A_REG_1 = 2'd2;
    localparam logic [2:0] ALU_SRC_B_REG_1 = 3'd0, ALU_SRC_B_SXT_5 = 3'd1, ALU_SRC_B_SXT_6 = 3'd2,
                           ALU_SRC_B_SXT_9 = 3'd3, ALU_SRC_B_SXT_11 = 3'd4;

    localparam logic [3:0] OP_BR = 4'b0000, OP_ADD = 4'b0001, OP_LD = 4'b0010, OP_ST = 4'b0011,
                           OP_JSR = 4'b0100, OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111,
                           OP_NOT = 4'b1001, OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                           OP_LEA = 4'b1110;

    typedef enum logic [2:0] {
        FETCH    = 3'd0,
        DECODE   = 3'd1,
        EXECUTE  = 3'd2,
        EXECUTE2 = 3'd3,
        HALT     = 3'd4
    } state_t;

    typedef struct packed {
        logic       ir_w_en;
        logic       pc_ld;
        logic       mem_w_en;
        logic       rf_w_en;
        logic       indirect_en;
        logic       status_ld;
        logic [1:0] pc_src_sel;
        logic [2:0] mem_r_addr_sel;
        logic       mem_w_addr_sel;
        logic       rf_r_addr_0_sel;
        logic       rf_r_addr_1_sel;
        logic       rf_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       status_src_sel;
        logic [1:0] alu_op;
        logic [1:0] alu_A_sel;
        logic [2:0] alu_B_sel;
        logic       halted;
    } ctrl_t;

    state_t state_r;
    state_t next_state_s;
    ctrl_t  ctrl_r;
    ctrl_t  ctrl_s;
    logic   unused_ir_bits_s;

    assign unused_ir_bits_s = ^{bus.ir[8:6], bus.ir[4:0]};

    // Control word a given state presents; ir and N/Z/P are stable across the instruction.
    function automatic ctrl_t decode_ctrl(input state_t st, input logic [15:0] instr,
                                          input logic n, input logic z, input logic p);
        ctrl_t c;
        c = '0;
        case (st)
            FETCH: begin
                c.mem_r_addr_sel = MEM_R_PC;
                c.ir_w_en        = 1'b1;
            end
            DECODE: begin
                c.pc_ld      = 1'b1;
                c.pc_src_sel = PC_SRC_SEL_INC;
            end
            EXECUTE: begin
                case (instr[15:12])
                    OP_ADD, OP_AND, OP_NOT: begin
                        c.rf_r_addr_0_sel = RF_R0_IR_8_6;
                        c.rf_r_addr_1_sel = RF_R1_IR_2_0;
                        c.alu_A_sel       = ALU_SRC_A_REG_0;
                        c.alu_B_sel       = instr[5] ? ALU_SRC_B_SXT_5 : ALU_SRC_B_REG_1;
                        c.alu_op          = (instr[15:12] == OP_ADD) ? ALU_FN_ADD :
                                            (instr[15:12] == OP_AND) ? ALU_FN_AND : ALU_FN_NOT;
                        c.rf_w_en         = 1'b1;
                        c.rf_w_addr_sel   = RF_W_ADDR_IR_11_9;
                        c.rf_w_data_sel   = RF_W_DATA_ALU;
                        c.status_ld       = 1'b1;
                        c.status_src_sel  = STATUS_SRC_SEL_ALU;
                    end
                    OP_BR: begin
                        if ((instr[11] & n) | (instr[10] & z) | (instr[9] & p)) begin
                            c.pc_ld      = 1'b1;
                            c.pc_src_sel = PC_SRC_SEL_ALU;
                            c.alu_A_sel  = ALU_SRC_A_PC;
                            c.alu_B_sel  = ALU_SRC_B_SXT_9;
                            c.alu_op     = ALU_FN_ADD;
                        end else begin
                            c.pc_ld = 1'b0;
                        end
                    end
                    OP_JMP: begin
                        c.pc_ld           = 1'b1;
                        c.pc_src_sel      = PC_SRC_SEL_REG;
                        c.rf_r_addr_0_sel = RF_R0_IR_8_6;
                    end
                    OP_JSR: begin
                        // R7 capture and the jump share one edge; the target reads the old R7.
                        c.rf_w_en         = 1'b1;
                        c.rf_w_addr_sel   = RF_W_ADDR_R7;
                        c.rf_w_data_sel   = RF_W_DATA_PC;
                        c.pc_ld           = 1'b1;
                        c.rf_r_addr_0_sel = RF_R0_IR_8_6;
                        c.alu_A_sel       = ALU_SRC_A_PC;
                        c.alu_B_sel       = ALU_SRC_B_SXT_11;
                        c.alu_op          = ALU_FN_ADD;
                        c.pc_src_sel      = instr[11] ? PC_SRC_SEL_ALU : PC_SRC_SEL_REG;
                    end
                    OP_LD, OP_LDR, OP_ST, OP_STR: begin
                        c.rf_r_addr_0_sel = RF_R0_IR_11_9;
                        c.rf_r_addr_1_sel = RF_R1_IR_8_6;
                        c.alu_op          = ALU_FN_ADD;
                        c.alu_A_sel       = instr[14] ? ALU_SRC_A_REG_1 : ALU_SRC_A_PC;
                        c.alu_B_sel       = instr[14] ? ALU_SRC_B_SXT_6 : ALU_SRC_B_SXT_9;
                        if (instr[12]) begin
                            c.mem_w_en       = 1'b1;
                            c.mem_w_addr_sel = MEM_W_ALU;
                        end else begin
                            c.mem_r_addr_sel = MEM_R_ALU;
                            c.rf_w_en        = 1'b1;
                            c.rf_w_addr_sel  = RF_W_ADDR_IR_11_9;
                            c.rf_w_data_sel  = RF_W_DATA_MEM;
                            c.status_ld      = 1'b1;
                            c.status_src_sel = STATUS_SRC_SEL_MEM;
                        end
                    end
                    OP_LEA: begin
                        c.rf_w_en       = 1'b1;
                        c.rf_w_addr_sel = RF_W_ADDR_IR_11_9;
                        c.rf_w_data_sel = RF_W_DATA_ALU;
                        c.alu_A_sel     = ALU_SRC_A_PC;
                        c.alu_B_sel     = ALU_SRC_B_SXT_9;
                        c.alu_op        = ALU_FN_ADD;
`ifdef PUNC_LEA_SETCC_EN
                        c.status_ld      = 1'b1;
                        c.status_src_sel = STATUS_SRC_SEL_ALU;
`else
                        c.status_ld      = 1'b0;
`endif
                    end
                    OP_LDI, OP_STI: begin
                        c.mem_r_addr_sel = MEM_R_ALU;
                        c.alu_A_sel      = ALU_SRC_A_PC;
                        c.alu_B_sel      = ALU_SRC_B_SXT_9;
                        c.alu_op         = ALU_FN_ADD;
                        c.indirect_en    = 1'b1;
                    end
                    default: c.pc_ld = 1'b0;
                endcase
            end
            EXECUTE2: begin
                if (instr[15:12] == OP_LDI) begin
                    c.mem_r_addr_sel = MEM_R_IND;
                    c.rf_w_en        = 1'b1;
                    c.rf_w_addr_sel  = RF_W_ADDR_IR_11_9;
                    c.rf_w_data_sel  = RF_W_DATA_MEM;
                    c.status_ld      = 1'b1;
                    c.status_src_sel = STATUS_SRC_SEL_MEM;
                end else begin
                    c.mem_w_en        = 1'b1;
                    c.mem_w_addr_sel  = MEM_W_IND;
                    c.rf_r_addr_0_sel = RF_R0_IR_11_9;
                end
            end
            HALT:    c.halted = 1'b1;
            default: c.halted = 1'b0;
        endcase
        return c;
    endfunction

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            FETCH:    next_state_s = DECODE;
            DECODE:   next_state_s = EXECUTE;
            EXECUTE: begin
                if ((bus.ir[15:12] == OP_LDI) || (bus.ir[15:12] == OP_STI)) begin
                    next_state_s = EXECUTE2;
                end else if (bus.ir[15:12] == HALT_OPCODE) begin
                    next_state_s = HALT;
                end else begin
                    next_state_s = FETCH;
                end
            end
            EXECUTE2: next_state_s = FETCH;
            HALT:     next_state_s = HALT;
            default:  next_state_s = FETCH;
        endcase
    end

    // State register with the control word of the state being entered registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= FETCH;
            ctrl_r  <= decode_ctrl(FETCH, bus.ir, bus.N, bus.Z, bus.P);
        end else begin
            state_r <= next_state_s;
            ctrl_r  <= decode_ctrl(next_state_s, bus.ir, bus.N, bus.Z, bus.P);
        end
    end

    // Reset blanks every control immediately so an aborted instruction writes nothing.
    always_comb begin
        if (rst) begin
            ctrl_s = '0;
        end else begin
            ctrl_s = ctrl_r;
        end
    end

    assign bus.ir_w_en         = ctrl_s.ir_w_en;
    assign bus.pc_ld           = ctrl_s.pc_ld;
    assign bus.mem_w_en        = ctrl_s.mem_w_en;
    assign bus.rf_w_en         = ctrl_s.rf_w_en;
    assign bus.indirect_en     = ctrl_s.indirect_en;
    assign bus.status_ld       = ctrl_s.status_ld;
    assign bus.pc_src_sel      = ctrl_s.pc_src_sel;
    assign bus.mem_r_addr_sel  = ctrl_s.mem_r_addr_sel;
    assign bus.mem_w_addr_sel  = ctrl_s.mem_w_addr_sel;
    assign bus.rf_r_addr_0_sel = ctrl_s.rf_r_addr_0_sel;
    assign bus.rf_r_addr_1_sel = ctrl_s.rf_r_addr_1_sel;
    assign bus.rf_w_addr_sel   = ctrl_s.rf_w_addr_sel;
    assign bus.rf_w_data_sel   = ctrl_s.rf_w_data_sel;
    assign bus.status_src_sel  = ctrl_s.status_src_sel;
    assign bus.alu_op          = ctrl_s.alu_op;
    assign bus.alu_A_sel       = ctrl_s.alu_A_sel;
    assign bus.alu_B_sel       = ctrl_s.alu_B_sel;
    assign bus.halted          = ctrl_s.halted;
endmodule
